// File: rtl/frame_buffer_ctrl.sv
// Frame buffer sequencer: arbitrates the pixel SRAM between the camera-side
// writer (pixcopy) and the SPI-side word readout, one frame per arm request.
module frame_buffer_ctrl #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 4096,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              arm,
    input  logic              abort,
    input  logic              newframe,
    input  logic              cap_write,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic [DATA_W-1:0] cap_data,
    output logic              capture_en,
    output logic              addrclr,
    input  logic              rd_req,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              sram_wren,
    output logic [ADDR_W-1:0] sram_wraddr,
    output logic [DATA_W-1:0] sram_data,
    output logic [ADDR_W-1:0] sram_rdaddr,
    input  logic [DATA_W-1:0] sram_q,
    output logic [2:0]        state,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              busy
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StCapture = 3'd2,
        StReady   = 3'd3,
        StReadout = 3'd4
    } state_e;

    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] CntOne   = (ADDR_W + 1)'(1);

    state_e              state_q, state_d;
    logic [ADDR_W:0]     word_count_q, word_count_d;
    logic                overflow_q, overflow_d;
    logic                capture_en_q;
    logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0]   rdaddr_q;
    logic [RD_LAT-1:0]   vpipe_q, vpipe_d;

    logic wr_req;
    logic wr_room;
    logic rd_window;
    logic rd_accept;

    // An aborting cycle never commits a write, so word_count stays frozen on abort.
    assign wr_req    = cap_write & capture_en_q & ~abort;
    assign wr_room   = word_count_q < DepthCnt;
    assign rd_window = ((state_q == StReady) && (word_count_q != '0)) ||
                       (state_q == StReadout);
    assign rd_accept = rd_req & rd_window & (rd_ptr_q < word_count_q) & ~abort;

    assign sram_wren   = wr_req & wr_room;
    assign sram_wraddr = cap_addr;
    assign sram_data   = cap_data;
    assign sram_rdaddr = rdaddr_q;

    assign capture_en = capture_en_q;
    assign rd_valid   = vpipe_q[RD_LAT-1];
    assign rd_data    = rd_valid ? sram_q : '0;
    assign state      = state_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle) && (state_q != StReady);

    // Next-state, capture counters and the address-clear strobe.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        addrclr      = 1'b0;

        if (wr_req && wr_room) begin
            word_count_d = word_count_q + CntOne;
        end
        if (wr_req && !wr_room) begin
            overflow_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d    = StArmed;
                    overflow_d = 1'b0;
                end
            end
            StArmed: begin
                if (newframe) begin
                    state_d      = StCapture;
                    addrclr      = 1'b1;
                    word_count_d = '0;
                end
            end
            StCapture: begin
                if (newframe) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (word_count_q == '0) begin
                    state_d = StIdle;
                end else if (rd_req) begin
                    state_d = StReadout;
                end
            end
            StReadout: begin
                if ((rd_ptr_q == word_count_q) && (vpipe_q == '0)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort) begin
            state_d      = StIdle;
            addrclr      = 1'b0;
            word_count_d = word_count_q;
            overflow_d   = overflow_q;
        end
    end

    // Read pointer restarts from zero whenever the buffer is not being read.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        if ((state_q != StReady) && (state_q != StReadout)) begin
            rd_ptr_d = '0;
        end else if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + CntOne;
        end
    end

    // Valid shift register tracks accepted requests through the SRAM latency.
    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = rd_accept;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end
        if (abort) begin
            vpipe_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= StIdle;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
            capture_en_q <= 1'b0;
            rd_ptr_q     <= '0;
            rdaddr_q     <= '0;
            vpipe_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
            capture_en_q <= (state_d == StCapture);
            rd_ptr_q     <= rd_ptr_d;
            vpipe_q      <= vpipe_d;
            if (rd_accept) begin
                rdaddr_q <= rd_ptr_q[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Directed bench for frame_buffer_ctrl with a behavioural SRAM.
module tb_frame_buffer_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          res, arm, abort, newframe, cap_write, rd_req;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic          capture_en, addrclr, rd_valid, sram_wren, overflow, busy;
    logic [DW-1:0] rd_data, sram_data, sram_q;
    logic [AW-1:0] sram_wraddr, sram_rdaddr;
    logic [2:0]    state;
    logic [AW:0]   word_count;

    logic [DW-1:0] mem [0:DEPTH-1];
    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int base;

    frame_buffer_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RD_LAT(2)) dut (
        .clk(clk), .res(res), .arm(arm), .abort(abort), .newframe(newframe),
        .cap_write(cap_write), .cap_addr(cap_addr), .cap_data(cap_data),
        .capture_en(capture_en), .addrclr(addrclr), .rd_req(rd_req),
        .rd_valid(rd_valid), .rd_data(rd_data), .sram_wren(sram_wren),
        .sram_wraddr(sram_wraddr), .sram_data(sram_data), .sram_rdaddr(sram_rdaddr),
        .sram_q(sram_q), .state(state), .word_count(word_count),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // SRAM: one register stage after the controller's address register.
    always @(posedge clk) begin
        if (sram_wren) mem[sram_wraddr] <= sram_data;
        sram_q <= mem[sram_rdaddr];
    end

    always @(posedge clk) if (sram_wren) wr_cnt++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        res = 1'b1;
        tick();
        tick();
        res = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if (capture_en !== 1'b0) begin n_bad++; $display("FAIL reset_capture_en: got %b want 0", capture_en); end
        n_cmp++; if (addrclr !== 1'b0) begin n_bad++; $display("FAIL reset_addrclr: got %b want 0", addrclr); end
        n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL reset_word_count: got %0d want 0", word_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_cmp++; if (sram_rdaddr !== 12'd0) begin n_bad++; $display("FAIL reset_rdaddr: got %0d want 0", sram_rdaddr); end
    endtask

    task automatic test_basic_capture;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL cap_armed: got %0d want 1", state); end
        newframe = 1'b1;
        #1;
        n_cmp++; if (addrclr !== 1'b1) begin n_bad++; $display("FAIL cap_addrclr_hi: got %b want 1", addrclr); end
        tick();
        newframe = 1'b0;
        #1;
        n_cmp++; if (addrclr !== 1'b0) begin n_bad++; $display("FAIL cap_addrclr_lo: got %b want 0", addrclr); end
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL cap_state: got %0d want 2", state); end
        n_cmp++; if (capture_en !== 1'b1) begin n_bad++; $display("FAIL cap_en: got %b want 1", capture_en); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cap_busy: got %b want 1", busy); end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL cap_arm_ignored: got %0d want 2", state); end
        base = wr_cnt;
        for (int i = 0; i < 10; i++) begin
            cap_write = 1'b1;
            cap_addr  = AW'(i);
            cap_data  = 16'hA000 + DW'(i);
            tick();
        end
        cap_write = 1'b0;
        newframe  = 1'b1;
        tick();
        newframe = 1'b0;
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL cap_ready: got %0d want 3", state); end
        n_cmp++; if (word_count !== 13'd10) begin n_bad++; $display("FAIL cap_count: got %0d want 10", word_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL cap_overflow: got %b want 0", overflow); end
        n_cmp++; if (capture_en !== 1'b0) begin n_bad++; $display("FAIL cap_en_fall: got %b want 0", capture_en); end
        n_cmp++; if (wr_cnt - base !== 10) begin n_bad++; $display("FAIL cap_wren_count: got %0d want 10", wr_cnt - base); end
    endtask

    task automatic test_back_to_back;
        logic exp_v;
        for (int j = 0; j < 14; j++) begin
            rd_req = (j <= 10);
            @(negedge clk);
            exp_v = (j >= 2) && (j <= 11);
            n_cmp++;
            if (rd_valid !== exp_v) begin
                n_bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", j, rd_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (rd_data !== 16'hA000 + DW'(j - 2)) begin
                    n_bad++; $display("FAIL b2b_data[%0d]: got %h want %h", j, rd_data, 16'hA000 + DW'(j - 2));
                end
            end
            tick();
        end
        rd_req = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL b2b_idle: got %0d want 0", state); end
        n_cmp++; if (word_count !== 13'd10) begin n_bad++; $display("FAIL b2b_count: got %0d want 10", word_count); end
    endtask

    task automatic test_overflow;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        base = wr_cnt;
        for (int i = 0; i < DEPTH + 5; i++) begin
            cap_write = 1'b1;
            cap_addr  = AW'(i);
            cap_data  = DW'(i);
            tick();
        end
        cap_write = 1'b0;
        newframe  = 1'b1;
        tick();
        newframe = 1'b0;
        n_cmp++; if (wr_cnt - base !== 4096) begin n_bad++; $display("FAIL ovf_wren_count: got %0d want 4096", wr_cnt - base); end
        n_cmp++; if (word_count !== 13'd4096) begin n_bad++; $display("FAIL ovf_count: got %0d want 4096", word_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL ovf_ready: got %0d want 3", state); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL ovf_abort_idle: got %0d want 0", state); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_abort_keeps: got %b want 1", overflow); end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_arm_clears: got %b want 0", overflow); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_boundary;
        arm = 1'b1;
        newframe = 1'b1;
        tick();
        arm = 1'b0;
        newframe = 1'b0;
        tick();
        n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL bnd_arm_nf: got %0d want 1", state); end
        base = wr_cnt;
        cap_write = 1'b1;
        cap_addr  = 12'd7;
        newframe  = 1'b1;
        #1;
        n_cmp++; if (sram_wren !== 1'b0) begin n_bad++; $display("FAIL bnd_drop_wren: got %b want 0", sram_wren); end
        tick();
        cap_write = 1'b0;
        newframe  = 1'b0;
        n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL bnd_capture: got %0d want 2", state); end
        n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL bnd_drop_count: got %0d want 0", word_count); end
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL bnd_zero_ready: got %0d want 3", state); end
        rd_req = 1'b1;
        tick();
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL bnd_zero_idle: got %0d want 0", state); end
        tick();
        tick();
        rd_req = 1'b0;
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL bnd_zero_noread: got %b want 0", rd_valid); end
        n_cmp++; if (wr_cnt - base !== 0) begin n_bad++; $display("FAIL bnd_wren_count: got %0d want 0", wr_cnt - base); end
    endtask

    task automatic test_abort_readout;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cap_write = 1'b1;
            cap_addr  = AW'(i);
            cap_data  = 16'h5000 + DW'(i);
            tick();
        end
        cap_write = 1'b0;
        newframe  = 1'b1;
        tick();
        newframe = 1'b0;
        rd_req = 1'b1;
        tick();
        tick();
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b1) begin n_bad++; $display("FAIL abt_valid0: got %b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 16'h5000) begin n_bad++; $display("FAIL abt_data0: got %h want 5000", rd_data); end
        tick();
        rd_req = 1'b0;
        abort  = 1'b1;
        @(negedge clk);
        n_cmp++; if (rd_data !== 16'h5001) begin n_bad++; $display("FAIL abt_data1: got %h want 5001", rd_data); end
        tick();
        abort = 1'b0;
        @(negedge clk);
        n_cmp++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL abt_suppress: got %b want 0", rd_valid); end
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL abt_idle: got %0d want 0", state); end
        n_cmp++; if (word_count !== 13'd6) begin n_bad++; $display("FAIL abt_count: got %0d want 6", word_count); end
        tick();
    endtask

    task automatic test_reset_mid_capture;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        newframe = 1'b1;
        tick();
        newframe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cap_write = 1'b1;
            cap_addr  = AW'(i);
            cap_data  = 16'h3000 + DW'(i);
            tick();
        end
        n_cmp++; if (word_count !== 13'd5) begin n_bad++; $display("FAIL rst_pre_count: got %0d want 5", word_count); end
        res = 1'b1;
        tick();
        res = 1'b0;
        base = wr_cnt;
        #1;
        n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_cmp++; if (capture_en !== 1'b0) begin n_bad++; $display("FAIL rst_capture_en: got %b want 0", capture_en); end
        n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", word_count); end
        n_cmp++; if (sram_wren !== 1'b0) begin n_bad++; $display("FAIL rst_wren: got %b want 0", sram_wren); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        tick();
        tick();
        tick();
        cap_write = 1'b0;
        n_cmp++; if (wr_cnt - base !== 0) begin n_bad++; $display("FAIL rst_late_writes: got %0d want 0", wr_cnt - base); end
        n_cmp++; if (word_count !== 13'd0) begin n_bad++; $display("FAIL rst_late_count: got %0d want 0", word_count); end
    endtask

    initial begin
        res = 1'b1; arm = 1'b0; abort = 1'b0; newframe = 1'b0;
        cap_write = 1'b0; cap_addr = '0; cap_data = '0; rd_req = 1'b0;
        test_reset();
        test_basic_capture();
        test_back_to_back();
        test_overflow();
        test_boundary();
        test_abort_readout();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/frame_buffer_ctrl.md
Name: frame_buffer_ctrl

Overview:
- Sequences the 4096x16 pixel SRAM between two users: the camera-side writer (pixcopy) and the SPI-side readout.
- Runs one frame per arm request: wait for the next frame start, capture one frame, hold the buffer, then stream it out word by word on request.
- Replaces the free-running vline_capture enable as the gate on pixcopy and owns every SRAM port.

Parameters:
- ADDR_W, 12, SRAM address width.
- DATA_W, 16, SRAM word width.
- DEPTH, 4096, buffer capacity in words; must be at most 2^ADDR_W.
- RD_LAT, 2, clk cycles from sram_rdaddr being presented to sram_q being valid.

Ports:
- clk  in  1  system clock (PLL c0); the only clock.
- res  in  1  synchronous reset, active-high.
- arm  in  1  one-cycle pulse; request capture of the next frame.
- abort  in  1  one-cycle pulse; return to IDLE from any state.
- newframe  in  1  one-cycle pulse at frame boundary (vsync-derived).
- cap_write  in  1  write strobe from pixcopy.
- cap_addr  in  ADDR_W  write address from pixcopy.
- cap_data  in  DATA_W  write data from pixcopy.
- capture_en  out  1  enable to pixcopy.
- addrclr  out  1  one-cycle pulse that clears the pixcopy address counter.
- rd_req  in  1  request for one readout word; may be asserted every cycle.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_W  readout word.
- sram_wren  out  1  SRAM write enable.
- sram_wraddr  out  ADDR_W  SRAM write address.
- sram_data  out  DATA_W  SRAM write data.
- sram_rdaddr  out  ADDR_W  SRAM read address.
- sram_q  in  DATA_W  SRAM read data.
- state  out  3  encoded state: IDLE=0, ARMED=1, CAPTURE=2, READY=3, READOUT=4.
- word_count  out  ADDR_W+1  number of words captured.
- overflow  out  1  sticky: frame exceeded DEPTH.
- busy  out  1  high when state is neither IDLE nor READY.

Behaviour:
- Reset values: state IDLE; all outputs 0; read pointer and read pipeline cleared.
- Write path is combinational: sram_wren = cap_write & capture_en & (word_count < DEPTH). sram_wraddr = cap_addr. sram_data = cap_data.
- capture_en is registered and is high only in CAPTURE.

State transitions:
- IDLE: arm -> ARMED. overflow is cleared on the transition. A newframe in the same cycle as arm is ignored.
- ARMED: newframe -> CAPTURE. In that same cycle: addrclr=1, word_count<=0, and any cap_write is dropped.
- CAPTURE, accepted write: word_count increments. Saturates at DEPTH.
- CAPTURE, cap_write while word_count==DEPTH: write is dropped and overflow<=1. State stays CAPTURE.
- CAPTURE, newframe: -> READY. capture_en falls the next cycle. A cap_write coincident with newframe is still accepted.
- READY: word_count==0 -> IDLE on the next cycle. Otherwise rd_req -> READOUT, and that rd_req is accepted as the first read.
- READOUT, accepted rd_req (rd_ptr < word_count): sram_rdaddr<=rd_ptr, rd_ptr increments. The request enters an RD_LAT-deep valid shift register.
- READOUT, rd_req with rd_ptr==word_count: ignored; no rd_valid.
- READOUT exit: -> IDLE once rd_ptr==word_count and the valid pipeline is empty.
- rd_valid/rd_data: asserted exactly RD_LAT cycles after each accepted request, in address order, one word per accepted request.
- arm outside IDLE: ignored. cap_write outside CAPTURE: ignored. rd_req outside READY/READOUT: ignored.

Abort and reset:
- abort, any state: -> IDLE next cycle. capture_en=0. The valid pipeline is flushed, so in-flight rd_valid is suppressed. word_count and overflow keep their values.
- abort together with arm: abort wins; state stays IDLE.
- res mid-operation: same as the reset values above, and overflow and word_count clear.

Test Plan:
- Basic capture: arm, newframe, 10 cap_write (addr 0..9, data 0xA000+i), newframe -> state=READY, word_count=10, overflow=0, addrclr high 1 cycle at the first newframe.
- Back-to-back readout of the 10-word frame: rd_req held 10 cycles -> rd_valid for 10 consecutive cycles starting RD_LAT=2 after the first rd_req, data 0xA000..0xA009, then state IDLE. An 11th rd_req produces no rd_valid.
- Overflow: DEPTH+5 writes before newframe -> exactly 4096 sram_wren, word_count=4096, overflow=1, state READY after newframe; a subsequent arm clears overflow.
- Boundary events:
  - arm and newframe in the same cycle -> ARMED; capture starts only at the next newframe.
  - cap_write coincident with the ARMED->CAPTURE newframe -> dropped.
  - zero-word frame -> READY then IDLE, with no read allowed.
- Abort mid-readout: after 3 reads issued, abort -> rd_valid suppressed from the next cycle, state IDLE, word_count unchanged.
- Reset mid-capture: res during CAPTURE with word_count=5 -> all outputs 0 the next cycle, and later writes are ignored.
